// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: FSM state encoding and default sizing shared by the data-memory controller
package dmem_ctrl_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_WAIT_STATES = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: memory-stage to data-memory controller bus
interface dmem_ctrl_if;

    logic [31:0] dmem_addr;
    logic        dmem_write_en;
    logic [31:0] dmem_val_out;
    logic        is_ld_op;
    logic        is_str_op;
    logic [31:0] dmem_val_in;
    logic        stall;
    logic        misaligned;

    modport master (
        output dmem_addr, dmem_write_en, dmem_val_out, is_ld_op, is_str_op,
        input  dmem_val_in, stall, misaligned
    );

    modport slave (
        input  dmem_addr, dmem_write_en, dmem_val_out, is_ld_op, is_str_op,
        output dmem_val_in, stall, misaligned
    );

endinterface

// File: rtl/dmem_ctrl_array.sv
// dmem_array: word storage with one synchronous write port and an enabled, registered read port
module dmem_array
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q, rdata_d;

    // read register only updates when a load completes, so it holds the last loaded word
    always_comb begin
        rdata_d = re ? mem[raddr] : rdata_q;
    end

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read register clears on reset
    always_ff @(posedge clk) begin
        rdata_q <= rst ? '0 : rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller with wait states, stall and misalignment rejection
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       data_q, data_d;
    logic              st_q, st_d;
    logic              req, aligned, accept, we, re;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign req     = bus.is_ld_op | bus.is_str_op;
    assign aligned = bus.dmem_addr[1:0] == 2'b00;
    assign accept  = state_q == ST_IDLE && req && aligned;

    // request latching and IDLE -> WAIT -> DONE sequencing; inputs only matter while IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        st_d    = st_q;
        if (accept) begin
            state_d = WAIT_STATES == 0 ? ST_DONE : ST_WAIT;
            cnt_d   = '0;
            idx_d   = bus.dmem_addr[ADDR_W+1:2];
            data_d  = bus.dmem_val_out;
            st_d    = bus.is_str_op;
        end else if (state_q == ST_WAIT) begin
            state_d = cnt_q == CNT_LAST ? ST_DONE : ST_WAIT;
            cnt_d   = cnt_q == CNT_LAST ? 4'd0 : cnt_q + 4'd1;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            st_q    <= st_d;
        end
    end

    // store commits on the edge leaving DONE; load is read on the edge entering DONE
    assign we = !rst && state_q == ST_DONE && st_q;
    assign re = !rst && state_d == ST_DONE && state_q != ST_DONE && !st_d;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (idx_q),
        .wdata (data_q),
        .re    (re),
        .raddr (idx_d),
        .rdata (rdata)
    );

    assign bus.stall       = !rst && (accept || state_q == ST_WAIT);
    assign bus.misaligned  = !rst && state_q == ST_IDLE && req && !aligned;
    assign bus.dmem_val_in = rst ? '0 : rdata;

    assign unused_bits = ^{bus.dmem_write_en, bus.dmem_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with two and zero wait states
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    dmem_ctrl_if b2();
    dmem_ctrl_if b0();

    dmem_ctrl #(.ADDR_W(10), .WAIT_STATES(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
    dmem_ctrl #(.ADDR_W(10), .WAIT_STATES(0)) d0 (.clk(clk), .rst(rst), .bus(b0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s, input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d);
        b2.is_ld_op      = ld & !s;
        b2.is_str_op     = st & !s;
        b0.is_ld_op      = ld & s;
        b0.is_str_op     = st & s;
        b2.dmem_addr     = a;
        b0.dmem_addr     = a;
        b2.dmem_val_out  = d;
        b0.dmem_val_out  = d;
        b2.dmem_write_en = st & !s;
        b0.dmem_write_en = st & s;
    endtask

    task automatic xfer(input string tag, input bit s, input bit ld, input bit st,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_cyc, input logic [31:0] exp_v, input logic exp_mis);
        int cyc;
        @(negedge clk);
        drive(s, ld, st, a, d);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!(s ? b0.stall : b2.stall)) break;
            cyc++;
            @(negedge clk);
        end
        check({tag, " stall_cycles"}, cyc, exp_cyc);
        check({tag, " val_in"}, s ? b0.dmem_val_in : b2.dmem_val_in, exp_v);
        check({tag, " misaligned"}, {31'd0, s ? b0.misaligned : b2.misaligned}, {31'd0, exp_mis});
        drive(s, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        b0.is_ld_op  = 1'b1;
        b0.dmem_addr = 32'h13;
        repeat (2) @(negedge clk);
        #1;
        check("rst stall2", {31'd0, b2.stall}, 32'd0);
        check("rst mis2", {31'd0, b2.misaligned}, 32'd0);
        check("rst val2", b2.dmem_val_in, 32'd0);
        check("rst stall0", {31'd0, b0.stall}, 32'd0);
        check("rst mis0", {31'd0, b0.misaligned}, 32'd0);
        check("rst val0", b0.dmem_val_in, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        xfer("st 0x10",      0, 0, 1, 32'h10,   32'hDEADBEEF, 3, 32'h0,        0);
        xfer("ld 0x10",      0, 1, 0, 32'h10,   32'h0,        3, 32'hDEADBEEF, 0);
        xfer("ld 0x13 mis",  0, 1, 0, 32'h13,   32'h0,        0, 32'hDEADBEEF, 1);
        xfer("st 0x12 mis",  0, 0, 1, 32'h12,   32'h99,       0, 32'hDEADBEEF, 1);
        xfer("ld 0x10 again",0, 1, 0, 32'h10,   32'h0,        3, 32'hDEADBEEF, 0);
        xfer("st 0x4",       0, 0, 1, 32'h4,    32'h0B0B0B0B, 3, 32'hDEADBEEF, 0);
        xfer("st 0x1000",    0, 0, 1, 32'h1000, 32'hA5A5A5A5, 3, 32'hDEADBEEF, 0);
        xfer("ld 0x0 wrap",  0, 1, 0, 32'h0,    32'h0,        3, 32'hA5A5A5A5, 0);
        xfer("st 0x20 old",  0, 0, 1, 32'h20,   32'hCAFE0020, 3, 32'hA5A5A5A5, 0);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h11111111);
        #1;
        check("abort accept stall", {31'd0, b2.stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort rst stall", {31'd0, b2.stall}, 32'd0);
        check("abort rst mis", {31'd0, b2.misaligned}, 32'd0);
        check("abort rst val", b2.dmem_val_in, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        xfer("ld 0x20 old",  0, 1, 0, 32'h20,   32'h0,        3, 32'hCAFE0020, 0);
        xfer("b2b ld 0x0",   0, 1, 0, 32'h0,    32'h0,        3, 32'hA5A5A5A5, 0);
        xfer("b2b ld 0x4",   0, 1, 0, 32'h4,    32'h0,        3, 32'h0B0B0B0B, 0);
        xfer("b2b ldst 0x8", 0, 1, 1, 32'h8,    32'h77,       3, 32'h0B0B0B0B, 0);
        xfer("ld 0x8",       0, 1, 0, 32'h8,    32'h0,        3, 32'h77,       0);

        xfer("ws0 st 0x4",   1, 0, 1, 32'h4,    32'h12345678, 1, 32'h0,        0);
        xfer("ws0 ld 0x4",   1, 1, 0, 32'h4,    32'h0,        1, 32'h12345678, 0);
        xfer("ws0 ld 0x5",   1, 1, 0, 32'h5,    32'h0,        0, 32'h12345678, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; the internal array holds 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_STATES, default 2, number of extra access cycles, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 dmem_addr  input  32  byte address from the memory stage.
REQ-006 dmem_write_en  input  1  store indication from the memory stage; informational only, with is_str_op as the decode source.
REQ-007 dmem_val_out  input  32  store data from the memory stage.
REQ-008 is_ld_op  input  1  load request.
REQ-009 is_str_op  input  1  store request.
REQ-010 dmem_val_in  output  32  load data returned to the memory stage.
REQ-011 stall  output  1  pipeline hold; the memory stage and its upstream registers freeze while it is high.
REQ-012 misaligned  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-013 A request exists when is_ld_op or is_str_op is high; when both are high, it is treated as a store.
REQ-014 Word index is dmem_addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
REQ-015 The FSM has three states: IDLE, WAIT and DONE.
REQ-016 In IDLE, an aligned request (dmem_addr[1:0]==0) latches the address, data and op, then moves to WAIT, or to DONE if WAIT_STATES==0.
REQ-017 In IDLE, a misaligned request is not accepted: misaligned pulses high that cycle, there is no stall, no write, dmem_val_in is unchanged, and the FSM stays in IDLE.
REQ-018 In WAIT, a 4-bit counter counts WAIT_STATES cycles, then the FSM moves to DONE.
REQ-019 DONE lasts one cycle and always returns to IDLE.
REQ-020 stall is combinational: high in IDLE while an aligned request is present, high in WAIT, low in DONE.
REQ-021 Latency: a request first seen in cycle 0 reaches DONE in cycle WAIT_STATES+1; the pipeline advances at the end of DONE.
REQ-022 Load: the array word is registered into dmem_val_in on the edge entering DONE; it is valid in DONE and held until the next load completes.
REQ-023 Store: the array is written on the edge that ends DONE; dmem_val_in is unchanged.
REQ-024 Inputs are ignored after acceptance until the FSM returns to IDLE; changes during WAIT or DONE have no effect.
REQ-025 Back-to-back requests: the cycle after DONE is IDLE and may accept the next request immediately; no request is ever accepted twice.
REQ-026 A load following a store to the same word returns the newly stored value.

Reset
REQ-027 While rst is high: FSM is IDLE, counter is 0, dmem_val_in is 0, stall is 0, misaligned is 0.
REQ-028 Reset during WAIT or DONE aborts the access: a pending store is not written and a pending load does not update dmem_val_in.
REQ-029 Array contents are not cleared by reset; array contents are undefined at power-up unless preloaded by the bench.

Structure
REQ-030 A shared package holds the FSM state encoding and the default ADDR_W and WAIT_STATES constants.
REQ-031 The storage is a sub-module dmem_array with one synchronous write port and a registered read port; dmem_ctrl holds the FSM, counter and latches.

Verification
REQ-032 Default WAIT_STATES=2: store 0xDEADBEEF to 0x10, then load 0x10 -> stall high 3 cycles per access; dmem_val_in=0xDEADBEEF in the load's DONE cycle.
REQ-033 WAIT_STATES=0: load of a preloaded word 0x12345678 at 0x4 -> stall high for 1 cycle; data valid in cycle 1.
REQ-034 Load at 0x13 -> misaligned high for 1 cycle, stall stays 0, array unchanged, dmem_val_in unchanged.
REQ-035 Store 0xA5A5A5A5 to 0x1000 with ADDR_W=10, then load 0x0 -> returns 0xA5A5A5A5 (address wrap).
REQ-036 Store 0x11111111 to 0x20 with rst asserted during WAIT, then load 0x20 -> returns the old value; all outputs are 0 during reset.
REQ-037 Two back-to-back loads to 0x0 and 0x4 plus simultaneous ld+str at 0x8 with data 0x77 -> each completes in 3 cycles; the 0x8 access acts as a store; a later load of 0x8 returns 0x77.
